ff_word_serializer: RTL and testbench
=====================================

# ff_word_serializer

- Bit-serial transmitter for the registered 32-bit state word that the flip-flop test designs capture each clock.
- Accepts a parallel word on a valid/ready handshake and shifts it out MSB first, one bit per clock, with framing strobes.
- Sits at the output end of the `always/ff` synthesis test family, where the `cs → ns` register is the capturing end.
- Synthesizes to FF/AND/mux primitives, with no latches.

## Interface
- `WIDTH`, default 32: word width in bits. Minimum 2.
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `in_valid`  in  1: `in_data` holds a word to send.
- `in_ready`  out  1: block accepts a word this cycle. Combinational from registered state.
- `in_data`  in  WIDTH: parallel word. Bit WIDTH-1 is sent first.
- `sout`  out  1: serial data bit. Forced 0 when `sout_valid`=0.
- `sout_valid`  out  1: `sout` carries a frame bit this cycle.
- `sout_first`  out  1: first bit of frame (data bit WIDTH-1).
- `sout_last`  out  1: final bit of frame.
- `busy`  out  1: state ≠ IDLE.

## Operation
- **Accept:** a word is accepted on a rising edge where `in_valid`=1 and `in_ready`=1. `in_data` is captured into shift register `sreg`. Bit counter `cnt` (width clog2(WIDTH)) is cleared.
- **State machine:**
  - IDLE: `in_ready`=1. Accept → SHIFT; otherwise stay in IDLE.
  - SHIFT: `sout`=`sreg[WIDTH-1]`. Each cycle `sreg` shifts left with 0 fill and `cnt` increments.
    - When `cnt`=WIDTH-1 (last data bit):
      - If the parity feature is enabled → PARITY.
      - Otherwise `in_ready`=1 this cycle. Accept → reload, `cnt`=0, stay in SHIFT (gapless frames). No accept → IDLE.
  - PARITY (only when the parity feature is enabled): one cycle. `sout` = stored parity bit and `in_ready`=1. Accept → SHIFT with new word; no accept → IDLE.
- **Framing strobes:**
  - `sout_first`=1 in SHIFT when `cnt`=0.
  - `sout_last`=1 on the final frame bit: SHIFT with `cnt`=WIDTH-1 when parity is disabled, or the PARITY cycle when enabled.
- **Handshake rules:**
  - `in_valid` while `in_ready`=0 is ignored; no word is queued.
  - `in_data` is sampled only at the accepting edge.
- **Reset** (any time, including mid-frame): state=IDLE, `sreg`=0, `cnt`=0, parity bit=0. The current frame is abandoned with no `sout_last`.
  - Output values during reset: `sout`=0, `sout_valid`=0, `sout_first`=0, `sout_last`=0, `busy`=0, `in_ready`=1.

## Timing
- **Latency:** a word accepted at edge k puts data bit WIDTH-1 on `sout` during cycle k+1 (after edge k). Bit WIDTH-1-i appears in cycle k+1+i.
- **Frame length:**
  - WIDTH cycles without parity.
  - WIDTH+1 cycles with parity.
- **Throughput:** with `in_valid` held high, frames are back-to-back with zero idle cycles. `sout_first` of frame n+1 immediately follows `sout_last` of frame n.
- **Reset release:** a word can be accepted on the first rising edge after `rst` deasserts.
- **Registered outputs:** `sout`, `sout_valid`, `sout_first`, `sout_last` and `busy` come from registers only, with no combinational path from inputs.
- **`in_ready`:** a function of state and `cnt` only, with no path from `in_valid`.

## Configuration
- Macro: `FF_WORD_SERIALIZER_PARITY_EN`.
- **Defined:**
  - Even parity (XOR of all `in_data` bits) is computed at accept and stored.
  - It is sent as an extra trailing bit in the PARITY state.
  - Frame length is WIDTH+1.
- **Undefined:**
  - No PARITY state and no parity register.
  - Frame length is WIDTH.
  - `in_ready` rises on the last data bit.

## Test plan
- **Reset values:** assert `rst` asynchronously mid-cycle → all outputs go to their reset values immediately, and `in_ready`=1.
- **Single word:** send 0x80000001 from idle (parity off) → `sout` sequence is 1, thirty 0s, 1 over cycles k+1..k+32.
  - `sout_first` only at k+1 and `sout_last` only at k+32.
  - Cycle k+33: `sout_valid`=0 and `busy`=0.
- **Back-to-back:** send 0xA5A5A5A5 then 0x0000FFFF with `in_valid` held high → 64 contiguous valid bits.
  - Second `sout_first` at k+33.
  - Second word accepted on the edge ending cycle k+32.
- **Ignored input while busy:** pulse `in_valid` with 0xFFFFFFFF during cycle k+10 of a 0x00000000 frame → ignored.
  - Output stays all 0s for 32 bits, then the block goes idle.
- **Reset mid-frame:** assert `rst` at cycle k+5 of 0xFFFFFFFF → `sout_valid` drops at once and no `sout_last` occurs.
  - After release, 0x00000003 transmits correctly from its first bit.
- **Parity on:** build with `FF_WORD_SERIALIZER_PARITY_EN` and send 0x00000007 → 33-bit frame ending in parity bit 1.
  - `sout_last` asserts at k+33.
  - 0x00000003 yields parity 0.

Source files
------------

// File: rtl/ff_word_serializer_if.sv
// Handshake and serial-output bundle for ff_word_serializer.
// The slave modport is the serializer's view; master is the word source and serial sink.
interface ff_word_serializer_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             sout;
    logic             sout_valid;
    logic             sout_first;
    logic             sout_last;
    logic             busy;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  sout,
        input  sout_valid,
        input  sout_first,
        input  sout_last,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output sout,
        output sout_valid,
        output sout_first,
        output sout_last,
        output busy
    );
endinterface

// File: rtl/ff_word_serializer.sv
// MSB-first bit-serial transmitter with valid/ready word intake and first/last strobes.
// Define FF_WORD_SERIALIZER_PARITY_EN to append an even-parity bit to every frame.
module ff_word_serializer #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    ff_word_serializer_if.slave  bus
);
    localparam int              CNT_W    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

`ifdef FF_WORD_SERIALIZER_PARITY_EN
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PARITY} state_t;
`else
    typedef enum logic [0:0] {S_IDLE, S_SHIFT} state_t;
`endif

    function automatic logic f_parity(input logic [WIDTH-1:0] d);
        return ^d;
    endfunction

    state_t           r_state;
    logic [WIDTH-1:0] r_sreg;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sout;
    logic             r_sout_valid;
    logic             r_sout_first;
    logic             r_sout_last;
    logic             r_busy;

    state_t           w_state_nxt;
    logic [WIDTH-1:0] w_sreg_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_ready;
    logic             w_last_bit;
    logic             w_sout_nxt;
    logic             w_first_nxt;
    logic             w_last_nxt;

`ifdef FF_WORD_SERIALIZER_PARITY_EN
    logic             r_par;
    logic             w_par_nxt;
`endif

    always_comb begin
        w_ready     = 1'b0;
        w_state_nxt = r_state;
        w_sreg_nxt  = r_sreg;
        w_cnt_nxt   = r_cnt;
        w_last_bit  = (r_cnt == CNT_LAST);
`ifdef FF_WORD_SERIALIZER_PARITY_EN
        w_par_nxt   = r_par;
`endif
        case (r_state)
            S_IDLE: begin
                w_ready = 1'b1;
            end
            S_SHIFT: begin
                w_sreg_nxt = {r_sreg[WIDTH-2:0], 1'b0};
                w_cnt_nxt  = r_cnt + CNT_W'(1);
                if (w_last_bit) begin
                    w_cnt_nxt = '0;
`ifdef FF_WORD_SERIALIZER_PARITY_EN
                    w_state_nxt = S_PARITY;
`else
                    // Opening the intake on the last data bit makes frames gapless.
                    w_ready     = 1'b1;
                    w_state_nxt = S_IDLE;
`endif
                end
            end
`ifdef FF_WORD_SERIALIZER_PARITY_EN
            S_PARITY: begin
                w_ready     = 1'b1;
                w_state_nxt = S_IDLE;
            end
`endif
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (w_ready && bus.in_valid) begin
            w_state_nxt = S_SHIFT;
            w_sreg_nxt  = bus.in_data;
            w_cnt_nxt   = '0;
`ifdef FF_WORD_SERIALIZER_PARITY_EN
            w_par_nxt   = f_parity(bus.in_data);
`endif
        end
    end

    // Output strobes are decoded from next state so they leave the block as flops.
    always_comb begin
        w_sout_nxt  = (w_state_nxt == S_SHIFT) ? w_sreg_nxt[WIDTH-1] : 1'b0;
        w_first_nxt = (w_state_nxt == S_SHIFT) && (w_cnt_nxt == '0);
`ifdef FF_WORD_SERIALIZER_PARITY_EN
        if (w_state_nxt == S_PARITY) begin
            w_sout_nxt = w_par_nxt;
        end
        w_last_nxt  = (w_state_nxt == S_PARITY);
`else
        w_last_nxt  = (w_state_nxt == S_SHIFT) && (w_cnt_nxt == CNT_LAST);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_sreg       <= '0;
            r_cnt        <= '0;
            r_sout       <= 1'b0;
            r_sout_valid <= 1'b0;
            r_sout_first <= 1'b0;
            r_sout_last  <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_sreg       <= w_sreg_nxt;
            r_cnt        <= w_cnt_nxt;
            r_sout       <= w_sout_nxt;
            r_sout_valid <= (w_state_nxt != S_IDLE);
            r_sout_first <= w_first_nxt;
            r_sout_last  <= w_last_nxt;
            r_busy       <= (w_state_nxt != S_IDLE);
        end
    end

`ifdef FF_WORD_SERIALIZER_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_par <= 1'b0;
        end else begin
            r_par <= w_par_nxt;
        end
    end
`endif

    assign bus.in_ready   = w_ready;
    assign bus.sout       = r_sout;
    assign bus.sout_valid = r_sout_valid;
    assign bus.sout_first = r_sout_first;
    assign bus.sout_last  = r_sout_last;
    assign bus.busy       = r_busy;
endmodule

// File: tb/tb_ff_word_serializer.sv
// Directed bench for ff_word_serializer; covers both builds of FF_WORD_SERIALIZER_PARITY_EN.
module tb_ff_word_serializer;
    localparam int WIDTH = 32;
`ifdef FF_WORD_SERIALIZER_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif

    logic clk = 1'b0;
    logic rst;
    int   n_total = 0;
    int   n_bad   = 0;

    always #5 clk = ~clk;

    ff_word_serializer_if #(.WIDTH(WIDTH)) bus_if ();

    ff_word_serializer #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    task automatic check(input string tag, input logic got, input logic exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%b exp=%b t=%0t", tag, got, exp, $time);
        end
    endtask

    // Frame bit i: data MSB-first, then the hand-supplied parity bit.
    function automatic logic exp_bit(input logic [WIDTH-1:0] w, input logic par, input int i);
        if (i < WIDTH) return w[WIDTH-1-i];
        return par;
    endfunction

    task automatic chk_idle(input string tag);
        check({tag, " sout"},       bus_if.sout,       1'b0);
        check({tag, " sout_valid"}, bus_if.sout_valid, 1'b0);
        check({tag, " sout_first"}, bus_if.sout_first, 1'b0);
        check({tag, " sout_last"},  bus_if.sout_last,  1'b0);
        check({tag, " busy"},       bus_if.busy,       1'b0);
        check({tag, " in_ready"},   bus_if.in_ready,   1'b1);
    endtask

    task automatic chk_bit(input string tag, input int i, input logic eb, input logic ef, input logic el);
        check($sformatf("%s sout[%0d]", tag, i),  bus_if.sout,       eb);
        check($sformatf("%s valid[%0d]", tag, i), bus_if.sout_valid, 1'b1);
        check($sformatf("%s first[%0d]", tag, i), bus_if.sout_first, ef);
        check($sformatf("%s last[%0d]", tag, i),  bus_if.sout_last,  el);
        check($sformatf("%s busy[%0d]", tag, i),  bus_if.busy,       1'b1);
    endtask

    task automatic send_frame(input logic [WIDTH-1:0] w, input logic par, input string tag);
        @(negedge clk);
        check({tag, " ready_before"}, bus_if.in_ready, 1'b1);
        bus_if.in_valid = 1'b1;
        bus_if.in_data  = w;
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            if (i == 0) begin
                bus_if.in_valid = 1'b0;
                bus_if.in_data  = ~w;
            end
            chk_bit(tag, i, exp_bit(w, par, i), i == 0, i == FRAME - 1);
        end
        @(negedge clk);
        chk_idle({tag, " after"});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH-1:0] w0;
        logic [WIDTH-1:0] w1;
        bus_if.in_valid = 1'b0;
        bus_if.in_data  = '0;
        rst = 1'b1;
        #12;
        chk_idle("reset");
        @(negedge clk);
        rst = 1'b0;

        // Single word from idle: 1, thirty 0s, 1 (parity of two ones is 0).
        send_frame(32'h8000_0001, 1'b0, "single");

        // Back-to-back with in_valid held high.
        w0 = 32'hA5A5_A5A5;
        w1 = 32'h0000_FFFF;
        @(negedge clk);
        bus_if.in_valid = 1'b1;
        bus_if.in_data  = w0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            if (i == 0) bus_if.in_data = w1;
            if (i == FRAME) bus_if.in_valid = 1'b0;
            if (i < FRAME)
                chk_bit("b2b", i, exp_bit(w0, 1'b0, i), i == 0, i == FRAME - 1);
            else
                chk_bit("b2b", i, exp_bit(w1, 1'b0, i - FRAME), i == FRAME, i == 2 * FRAME - 1);
            if (i == FRAME - 2) check("b2b ready_early", bus_if.in_ready, 1'b0);
            if (i == FRAME - 1) check("b2b ready_last", bus_if.in_ready, 1'b1);
        end
        @(negedge clk);
        chk_idle("b2b after");

        // Pulse in_valid with all-ones while a zero word is shifting.
        @(negedge clk);
        bus_if.in_valid = 1'b1;
        bus_if.in_data  = '0;
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            if (i == 0) bus_if.in_valid = 1'b0;
            if (i == 9) begin
                check("ign ready_busy", bus_if.in_ready, 1'b0);
                bus_if.in_valid = 1'b1;
                bus_if.in_data  = 32'hFFFF_FFFF;
            end
            if (i == 10) bus_if.in_valid = 1'b0;
            chk_bit("ign", i, 1'b0, i == 0, i == FRAME - 1);
        end
        @(negedge clk);
        chk_idle("ign after");

        // Reset in cycle k+5 of an all-ones frame.
        @(negedge clk);
        bus_if.in_valid = 1'b1;
        bus_if.in_data  = 32'hFFFF_FFFF;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 0) bus_if.in_valid = 1'b0;
            chk_bit("rstmid", i, 1'b1, i == 0, 1'b0);
        end
        #2 rst = 1'b1;
        #1 chk_idle("rstmid async");
        @(negedge clk);
        chk_idle("rstmid held");
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("rstmid no_last[%0d]", i), bus_if.sout_last, 1'b0);
            check($sformatf("rstmid no_valid[%0d]", i), bus_if.sout_valid, 1'b0);
        end
        send_frame(32'h0000_0003, 1'b0, "post_rst");

`ifdef FF_WORD_SERIALIZER_PARITY_EN
        send_frame(32'h0000_0007, 1'b1, "par7");
        send_frame(32'h0000_0003, 1'b0, "par3");
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
